// File: rtl/mlp_stream_host.sv
// -----------------------------------------------------------------------------
// mlp_stream_host
//   Host-side sequencer for the mlp core. A single serial word stream is
//   unpacked into the core's weights1, weights2 and data_in arrays (row-major,
//   column index fastest). The core is then started with mlp_enable. On a fresh
//   rising edge of mlp_done the results are captured and streamed back out.
//   With keep_weights set at the end of a run, the next run reloads data_in only.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   keep_weights      sampled on the final result handshake; 1 = skip weight load
//   s_valid/s_ready   input word handshake, s_data = word
//   m_valid/m_ready   result word handshake, m_data = word, m_last = final word
//   busy              high while in START, WAIT_DONE or DRAIN
//   mlp_enable        start request to the core, held until done is captured
//   mlp_done          completion flag from the core
//   mlp_weights1      [INPUT_SIZE][HIDDEN_SIZE] words to the core
//   mlp_weights2      [HIDDEN_SIZE][OUTPUT_SIZE] words to the core
//   mlp_data_in       [COUNT][INPUT_SIZE] words to the core
//   mlp_data_out      [COUNT][OUTPUT_SIZE] words from the core
// -----------------------------------------------------------------------------
module mlp_stream_host #(
    parameter int INPUT_SIZE  = 4,
    parameter int HIDDEN_SIZE = 2,
    parameter int OUTPUT_SIZE = 1,
    parameter int COUNT       = 1,
    parameter int WORD_W      = 32
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               keep_weights,
    input  logic                                               s_valid,
    output logic                                               s_ready,
    input  logic [WORD_W-1:0]                                  s_data,
    output logic                                               m_valid,
    input  logic                                               m_ready,
    output logic [WORD_W-1:0]                                  m_data,
    output logic                                               m_last,
    output logic                                               busy,
    output logic                                               mlp_enable,
    input  logic                                               mlp_done,
    output logic [INPUT_SIZE-1:0][HIDDEN_SIZE-1:0][WORD_W-1:0] mlp_weights1,
    output logic [HIDDEN_SIZE-1:0][OUTPUT_SIZE-1:0][WORD_W-1:0] mlp_weights2,
    output logic [COUNT-1:0][INPUT_SIZE-1:0][WORD_W-1:0]       mlp_data_in,
    input  logic [COUNT-1:0][OUTPUT_SIZE-1:0][WORD_W-1:0]      mlp_data_out
);

    typedef enum logic [2:0] {
        LOAD_W1, LOAD_W2, LOAD_X, START, WAIT_DONE, DRAIN
    } state_t;

    // One row/column counter pair is shared by every phase, so it is sized
    // for the largest array dimension.
    localparam int MAX_A   = (INPUT_SIZE > HIDDEN_SIZE) ? INPUT_SIZE : HIDDEN_SIZE;
    localparam int MAX_B   = (COUNT > OUTPUT_SIZE) ? COUNT : OUTPUT_SIZE;
    localparam int MAX_DIM = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_DIM + 1);

    localparam logic [CNT_W-1:0] IN_LIM  = CNT_W'(INPUT_SIZE - 1);
    localparam logic [CNT_W-1:0] HID_LIM = CNT_W'(HIDDEN_SIZE - 1);
    localparam logic [CNT_W-1:0] OUT_LIM = CNT_W'(OUTPUT_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(COUNT - 1);

    state_t                                              state_q, state_d;
    logic [CNT_W-1:0]                                    row_q, row_d, col_q, col_d;
    logic [INPUT_SIZE-1:0][HIDDEN_SIZE-1:0][WORD_W-1:0]  w1_q, w1_d;
    logic [HIDDEN_SIZE-1:0][OUTPUT_SIZE-1:0][WORD_W-1:0] w2_q, w2_d;
    logic [COUNT-1:0][INPUT_SIZE-1:0][WORD_W-1:0]        x_q, x_d;
    logic [COUNT-1:0][OUTPUT_SIZE-1:0][WORD_W-1:0]       result_q, result_d;
    logic                                                done_q;
    logic                                                enable_q, enable_d;
    logic                                                s_ready_q, s_ready_d;
    logic                                                m_valid_q, m_valid_d;
    logic [WORD_W-1:0]                                   m_data_q, m_data_d;
    logic                                                m_last_q, m_last_d;
    logic                                                busy_q, busy_d;

    logic                                                s_hs, m_hs, step, last_elem;
    logic [CNT_W-1:0]                                    row_lim, col_lim;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        x_d      = x_q;
        result_d = result_q;
        enable_d = enable_q;
        row_lim  = '0;
        col_lim  = '0;

        case (state_q)
            LOAD_W1: begin row_lim = IN_LIM;  col_lim = HID_LIM; end
            LOAD_W2: begin row_lim = HID_LIM; col_lim = OUT_LIM; end
            LOAD_X:  begin row_lim = CNT_LIM; col_lim = IN_LIM;  end
            DRAIN:   begin row_lim = CNT_LIM; col_lim = OUT_LIM; end
            default: ;
        endcase

        // s_ready_q is only ever set while in a LOAD_* state.
        s_hs      = s_valid && s_ready_q;
        m_hs      = m_valid_q && m_ready;
        step      = s_hs || ((state_q == DRAIN) && m_hs);
        last_elem = (row_q == row_lim) && (col_q == col_lim);

        // Wraps to 0,0 after the last element, ready for the next phase.
        if (step) begin
            if (col_q == col_lim) begin
                col_d = '0;
                row_d = (row_q == row_lim) ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end

        for (int r = 0; r < INPUT_SIZE; r++)
            for (int c = 0; c < HIDDEN_SIZE; c++)
                if (s_hs && state_q == LOAD_W1 && row_q == CNT_W'(r) && col_q == CNT_W'(c))
                    w1_d[r][c] = s_data;
        for (int r = 0; r < HIDDEN_SIZE; r++)
            for (int c = 0; c < OUTPUT_SIZE; c++)
                if (s_hs && state_q == LOAD_W2 && row_q == CNT_W'(r) && col_q == CNT_W'(c))
                    w2_d[r][c] = s_data;
        for (int r = 0; r < COUNT; r++)
            for (int c = 0; c < INPUT_SIZE; c++)
                if (s_hs && state_q == LOAD_X && row_q == CNT_W'(r) && col_q == CNT_W'(c))
                    x_d[r][c] = s_data;

        case (state_q)
            LOAD_W1: if (s_hs && last_elem) state_d = LOAD_W2;
            LOAD_W2: if (s_hs && last_elem) state_d = LOAD_X;
            LOAD_X:  if (s_hs && last_elem) state_d = START;
            START: begin
                state_d  = WAIT_DONE;
                enable_d = 1'b1;
            end
            WAIT_DONE: begin
                // Only a fresh 0->1 edge counts; a level already high on entry
                // leaves done_q high and is ignored.
                if (mlp_done && !done_q) begin
                    result_d = mlp_data_out;
                    enable_d = 1'b0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: if (m_hs && last_elem) state_d = keep_weights ? LOAD_X : LOAD_W1;
            default: state_d = LOAD_W1;
        endcase

        // Handshake-facing outputs are registered from the next state.
        s_ready_d = (state_d == LOAD_W1) || (state_d == LOAD_W2) || (state_d == LOAD_X);
        busy_d    = (state_d == START) || (state_d == WAIT_DONE) || (state_d == DRAIN);
        m_valid_d = (state_d == DRAIN);
        m_last_d  = m_valid_d && (row_d == CNT_LIM) && (col_d == OUT_LIM);
        // result_d already holds mlp_data_out on the capture edge, so the first
        // word is presented in the same cycle m_valid rises.
        m_data_d  = '0;
        for (int n = 0; n < COUNT; n++)
            for (int o = 0; o < OUTPUT_SIZE; o++)
                if (m_valid_d && row_d == CNT_W'(n) && col_d == CNT_W'(o))
                    m_data_d = result_d[n][o];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the weight/data arrays are plain flops driving the core and
            // must read back as zero after reset, so they are reset too.
            state_q   <= LOAD_W1;
            row_q     <= '0;
            col_q     <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            x_q       <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            enable_q  <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            x_q       <= x_d;
            result_q  <= result_d;
            done_q    <= mlp_done;
            enable_q  <= enable_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_last       = m_last_q;
    assign busy         = busy_q;
    assign mlp_enable   = enable_q;
    assign mlp_weights1 = w1_q;
    assign mlp_weights2 = w2_q;
    assign mlp_data_in  = x_q;

endmodule

// File: tb/tb_mlp_stream_host.sv
// -----------------------------------------------------------------------------
// tb_mlp_stream_host
//   Bench for mlp_stream_host with default sizes. A stand-in for the mlp core
//   answers mlp_enable with a chosen result word; that word is pushed to a
//   scoreboard queue when driven and popped when the DUT streams it out.
// -----------------------------------------------------------------------------
module tb_mlp_stream_host;

    localparam int IN  = 4;
    localparam int HID = 2;
    localparam int OUT = 1;
    localparam int CNT = 1;
    localparam int W   = 32;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    logic                            keep_weights = 1'b0;
    logic                            s_valid = 1'b0;
    logic                            s_ready;
    logic [W-1:0]                    s_data = '0;
    logic                            m_valid;
    logic                            m_ready = 1'b0;
    logic [W-1:0]                    m_data;
    logic                            m_last;
    logic                            busy;
    logic                            mlp_enable;
    logic                            mlp_done = 1'b0;
    logic [IN-1:0][HID-1:0][W-1:0]   mlp_weights1;
    logic [HID-1:0][OUT-1:0][W-1:0]  mlp_weights2;
    logic [CNT-1:0][IN-1:0][W-1:0]   mlp_data_in;
    logic [CNT-1:0][OUT-1:0][W-1:0]  mlp_data_out = '0;

    mlp_stream_host #(
        .INPUT_SIZE(IN), .HIDDEN_SIZE(HID), .OUTPUT_SIZE(OUT), .COUNT(CNT), .WORD_W(W)
    ) dut (
        .clk(clk), .rst(rst), .keep_weights(keep_weights),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .mlp_enable(mlp_enable), .mlp_done(mlp_done),
        .mlp_weights1(mlp_weights1), .mlp_weights2(mlp_weights2),
        .mlp_data_in(mlp_data_in), .mlp_data_out(mlp_data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // arr: 0 = weights1, 1 = weights2, 2 = data_in
    typedef struct {
        logic [W-1:0] data;
        int           arr;
        int           r;
        int           c;
    } load_vec_t;

    load_vec_t vecs[14];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] elem(input int arr, input int r, input int c);
        logic [IN*HID*W-1:0]  f1;
        logic [HID*OUT*W-1:0] f2;
        logic [CNT*IN*W-1:0]  fx;
        f1 = mlp_weights1;
        f2 = mlp_weights2;
        fx = mlp_data_in;
        case (arr)
            0:       return f1[(r*HID + c)*W +: W];
            1:       return f2[(r*OUT + c)*W +: W];
            default: return fx[(r*IN + c)*W +: W];
        endcase
    endfunction

    // Entered and left at 1ns after a rising edge.
    task automatic send_word(input logic [W-1:0] d, output int waits);
        s_data  = d;
        s_valid = 1'b1;
        waits   = 0;
        @(negedge clk);
        while (!s_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        check("s_ready_for_word", {31'b0, s_ready}, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic core_done(input logic [W-1:0] v);
        mlp_data_out = v;
        mlp_done     = 1'b1;
        exp_q.push_back(v);
    endtask

    task automatic drain_one(input int stall);
        logic [W-1:0] exp;
        int           n;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("m_valid_drain", {31'b0, m_valid}, 1);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else begin
            exp = 'x;
            check("scoreboard_empty", 32'(exp_q.size()), 1);
        end
        m_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            check("bp_m_valid", {31'b0, m_valid}, 1);
            check("bp_m_data", m_data, exp);
            check("bp_m_last", {31'b0, m_last}, 1);
            @(negedge clk);
        end
        m_ready = 1'b1;
        check("m_data", m_data, exp);
        check("m_last", {31'b0, m_last}, 1);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        check("m_valid_after_last", {31'b0, m_valid}, 0);
        check("busy_after_last", {31'b0, busy}, 0);
        check("s_ready_after_last", {31'b0, s_ready}, 1);
    endtask

    task automatic wait_enable();
        int n;
        n = 0;
        while (!mlp_enable && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("enable_seen", {31'b0, mlp_enable}, 1);
    endtask

    initial begin
        int waits;
        int total_waits;

        for (int k = 0; k < 8; k++) vecs[k] = '{32'h3F000000, 0, k / HID, k % HID};
        for (int k = 0; k < 2; k++) vecs[8 + k] = '{32'h3F000000, 1, k, 0};
        vecs[10] = '{32'h3F800000, 2, 0, 0};
        vecs[11] = '{32'h40000000, 2, 0, 1};
        vecs[12] = '{32'h40400000, 2, 0, 2};
        vecs[13] = '{32'h40800000, 2, 0, 3};

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", {31'b0, s_ready}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_m_valid", {31'b0, m_valid}, 0);
        check("rst_m_last", {31'b0, m_last}, 0);
        check("rst_m_data", m_data, 0);
        check("rst_enable", {31'b0, mlp_enable}, 0);
        check("rst_w1_zero", {31'b0, mlp_weights1 != '0}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("s_ready_after_rst", {31'b0, s_ready}, 1);
        @(posedge clk);
        #1;

        // ---- run 1: full load, spurious done during LOAD_W2 ----
        total_waits = 0;
        for (int k = 0; k < 14; k++) begin
            send_word(vecs[k].data, waits);
            total_waits += waits;
            if (k == 7) begin
                mlp_done = 1'b1;
                @(posedge clk);
                #1;
                mlp_done = 1'b0;
                @(negedge clk);
                check("spurious_s_ready", {31'b0, s_ready}, 1);
                check("spurious_busy", {31'b0, busy}, 0);
                check("spurious_enable", {31'b0, mlp_enable}, 0);
                @(posedge clk);
                #1;
            end
        end
        check("load_throughput_waits", total_waits, 0);
        @(negedge clk);
        check("start_enable_low", {31'b0, mlp_enable}, 0);
        check("start_s_ready_low", {31'b0, s_ready}, 0);
        check("start_busy", {31'b0, busy}, 1);
        check("w1_3_1", mlp_weights1[3][1], 32'h3F000000);
        check("x_0_3", mlp_data_in[0][3], 32'h40800000);
        for (int k = 0; k < 14; k++) check("load_elem", elem(vecs[k].arr, vecs[k].r, vecs[k].c), vecs[k].data);
        @(negedge clk);
        check("enable_one_after_last", {31'b0, mlp_enable}, 1);
        check("wait_s_ready_low", {31'b0, s_ready}, 0);

        repeat (2) begin @(posedge clk); #1; end
        core_done(32'h40A00000);
        @(negedge clk);
        check("pre_capture_m_valid", {31'b0, m_valid}, 0);
        @(negedge clk);
        check("capture_m_valid", {31'b0, m_valid}, 1);
        check("capture_enable_low", {31'b0, mlp_enable}, 0);
        mlp_done     = 1'b0;
        keep_weights = 1'b1;
        drain_one(5);

        // ---- run 2: weight reuse, done held high across WAIT_DONE entry ----
        @(posedge clk);
        #1;
        mlp_done = 1'b1;
        for (int k = 0; k < 4; k++) send_word(32'h40000000, waits);
        @(negedge clk);
        check("run2_enable_low", {31'b0, mlp_enable}, 0);
        @(negedge clk);
        check("run2_enable_high", {31'b0, mlp_enable}, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_done_no_capture", {31'b0, m_valid}, 0);
        end
        @(posedge clk);
        #1;
        mlp_done = 1'b0;
        @(posedge clk);
        #1;
        core_done(32'h41000000);
        @(negedge clk);
        @(negedge clk);
        check("run2_capture", {31'b0, m_valid}, 1);
        wait_enable_low: check("run2_enable_cleared", {31'b0, mlp_enable}, 0);
        for (int k = 0; k < 10; k++) check("weights_kept", elem(vecs[k].arr, vecs[k].r, vecs[k].c), vecs[k].data);
        for (int c = 0; c < IN; c++) check("run2_x", elem(2, 0, c), 32'h40000000);
        mlp_done     = 1'b0;
        keep_weights = 1'b0;
        drain_one(0);

        // ---- run 3: reset mid-load ----
        @(posedge clk);
        #1;
        for (int k = 0; k < 12; k++) send_word(32'h00001000 + 32'(k), waits);
        check("mid_x_written", mlp_data_in[0][1], 32'h0000100B);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_w1_zero", {31'b0, mlp_weights1 != '0}, 0);
        check("mid_rst_w2_zero", {31'b0, mlp_weights2 != '0}, 0);
        check("mid_rst_x_zero", {31'b0, mlp_data_in != '0}, 0);
        check("mid_rst_s_ready", {31'b0, s_ready}, 0);
        @(posedge clk);
        #1;
        send_word(32'h12345678, waits);
        @(negedge clk);
        check("after_rst_w1_0_0", mlp_weights1[0][0], 32'h12345678);
        check("after_rst_w1_0_1", mlp_weights1[0][1], 32'h00000000);
        wait_enable_guard: if (mlp_enable) check("no_enable_after_rst", {31'b0, mlp_enable}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
